// File: rtl/data_mem_lat.sv
// Byte-addressed data memory with a fixed, parameterised access latency.
// State advances on the falling edge of CLK; RST is asynchronous and active-low.
module data_mem_lat #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req,
  input  logic        WEN,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  output logic        Busy,
  output logic        Done,
  output logic        Err,
  output logic [31:0] DataOut
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q, err_q;
  logic [31:0]   dout_q;
  logic          wen_q, uns_q;
  logic [1:0]    size_q;
  logic [31:0]   addr_q, din_q;

  logic [7:0] mem [DEPTH];

  // With LATENCY=1 the access happens on the acceptance edge itself, so the
  // operands come straight from the ports instead of the capture registers.
  logic        a_wen, a_uns;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_din;

  always_comb begin
    if (state_q == WAIT) begin
      a_wen  = wen_q;
      a_uns  = uns_q;
      a_size = size_q;
      a_addr = addr_q;
      a_din  = din_q;
    end else begin
      a_wen  = WEN;
      a_uns  = Unsigned;
      a_size = Size;
      a_addr = Addr;
      a_din  = DataIn;
    end
  end

  logic accept, enter_done;
  assign accept     = Req && (state_q != WAIT);
  assign enter_done = ((state_q == WAIT) && (cnt_q == '0)) || ((LATENCY == 1) && accept);

  logic [1:0]  last_off;
  logic [32:0] last_addr;
  logic        misalign, out_of_range, err_d;

  always_comb begin
    last_off = 2'd0;
    if (a_size == 2'b01) last_off = 2'd1;
    else if (a_size[1])  last_off = 2'd3;
  end

  // 33-bit sum so an access near 0xFFFFFFFF cannot wrap back into range.
  assign last_addr    = {1'b0, a_addr} + {31'b0, last_off};
  assign misalign     = ((a_size == 2'b01) && a_addr[0]) || (a_size[1] && (a_addr[1:0] != 2'b00));
  assign out_of_range = last_addr >= 33'(DEPTH);
  assign err_d        = misalign || out_of_range;

  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   load_val, dout_d;

  assign idx0 = a_addr[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);
  assign b0   = mem[idx0];
  assign b1   = mem[idx1];
  assign b2   = mem[idx2];
  assign b3   = mem[idx3];

  always_comb begin
    case (a_size)
      2'b00:   load_val = {{24{~a_uns & b0[7]}}, b0};
      2'b01:   load_val = {{16{~a_uns & b1[7]}}, b1, b0};
      default: load_val = {b3, b2, b1, b0};
    endcase
    dout_d = (a_wen && !err_d) ? load_val : 32'd0;
  end

  // Memory is never reset; a write needs RST high so a store pending when
  // reset arrives can never land.
  always_ff @(negedge CLK) begin
    if (RST && enter_done && !a_wen && !err_d) begin
      mem[idx0] <= a_din[7:0];
      if (a_size != 2'b00) mem[idx1] <= a_din[15:8];
      if (a_size[1]) begin
        mem[idx2] <= a_din[23:16];
        mem[idx3] <= a_din[31:24];
      end
    end
  end

  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 32'd0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      din_q   <= 32'd0;
    end else begin
      case (state_q)
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          if (accept) begin
            wen_q  <= WEN;
            uns_q  <= Unsigned;
            size_q <= Size;
            addr_q <= Addr;
            din_q  <= DataIn;
            if (LATENCY > 1) begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
      endcase
      if (enter_done) begin
        err_q  <= err_d;
        dout_q <= dout_d;
      end
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Err     = err_q;
  assign DataOut = dout_q;

endmodule

// File: tb/tb_data_mem_lat.sv
// Directed bench for data_mem_lat: LATENCY=2 main instance plus LATENCY=3 and
// LATENCY=1 instances for back-to-back and single-cycle behaviour.
module tb_data_mem_lat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        req, wen, uns;
  logic [1:0]  size;
  logic [31:0] addr, din;
  logic        busy, done, err;
  logic [31:0] dout;

  logic        req3, wen3, uns3;
  logic [1:0]  size3;
  logic [31:0] addr3, din3;
  logic        busy3, done3, err3;
  logic [31:0] dout3;

  logic        req1, wen1, uns1;
  logic [1:0]  size1;
  logic [31:0] addr1, din1;
  logic        busy1, done1, err1;
  logic [31:0] dout1;

  int checks = 0;
  int errors = 0;

  data_mem_lat #(.DEPTH(1024), .LATENCY(2)) dut (
    .CLK(clk), .RST(rst_n), .Req(req), .WEN(wen), .Size(size), .Unsigned(uns),
    .Addr(addr), .DataIn(din), .Busy(busy), .Done(done), .Err(err), .DataOut(dout)
  );

  data_mem_lat #(.DEPTH(64), .LATENCY(3)) dut3 (
    .CLK(clk), .RST(rst_n), .Req(req3), .WEN(wen3), .Size(size3), .Unsigned(uns3),
    .Addr(addr3), .DataIn(din3), .Busy(busy3), .Done(done3), .Err(err3), .DataOut(dout3)
  );

  data_mem_lat #(.DEPTH(64), .LATENCY(1)) dut1 (
    .CLK(clk), .RST(rst_n), .Req(req1), .WEN(wen1), .Size(size1), .Unsigned(uns1),
    .Addr(addr1), .DataIn(din1), .Busy(busy1), .Done(done1), .Err(err1), .DataOut(dout1)
  );

  // One request on the main instance; lat = posedges after acceptance until Done (0 = never).
  task automatic access(input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] o_dout, output logic o_err, output int lat);
    @(posedge clk);
    req = 1'b1; wen = w; size = s; uns = u; addr = a; din = d;
    @(negedge clk);
    lat = 0; o_dout = 'x; o_err = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      if (i == 1) req = 1'b0;
      if (done) begin
        lat = i; o_dout = dout; o_err = err;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 0; wen = 0; uns = 0; size = 0; addr = 0; din = 0;
    req3 = 0; wen3 = 0; uns3 = 0; size3 = 0; addr3 = 0; din3 = 0;
    req1 = 0; wen1 = 0; uns1 = 0; size1 = 0; addr1 = 0; din1 = 0;
    #3;
    checks++;
    if ({busy, done, err, dout} !== 35'd0) begin
      errors++;
      $display("FAIL reset_main: busy=%b done=%b err=%b dout=%h, required all 0", busy, done, err, dout);
    end
    checks++;
    if ({busy3, done3, err3, dout3, busy1, done1, err1, dout1} !== 70'd0) begin
      errors++;
      $display("FAIL reset_aux: busy3=%b done3=%b busy1=%b done1=%b, required all 0", busy3, done3, busy1, done1);
    end
    @(posedge clk);
    rst_n = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_store_load();
    logic [31:0] o; logic e; int lat;
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, o, e, lat);
    checks++;
    if (lat !== 2 || e !== 1'b0 || o !== 32'd0) begin
      errors++;
      $display("FAIL store_word: lat=%0d err=%b dout=%h, required lat=2 err=0 dout=00000000", lat, e, o);
    end
    $display("store word @10 lat=%0d err=%b", lat, e);
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, o, e, lat);
    checks++;
    if (lat !== 2 || e !== 1'b0 || o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL load_word: lat=%0d err=%b dout=%h, required lat=2 err=0 dout=deadbeef", lat, e, o);
    end
    $display("load word @10 lat=%0d dout=%h", lat, o);
  endtask

  task automatic test_load_ext();
    logic [1:0]  s_tab [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
    logic        u_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] a_tab [4] = '{32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] x_tab [4] = '{32'hFFFFFFDE, 32'h0000DEAD, 32'h000000EF, 32'hFFFFBEEF};
    logic [31:0] o; logic e; int lat;
    for (int i = 0; i < 4; i++) begin
      access(1'b1, s_tab[i], u_tab[i], a_tab[i], 32'h0, o, e, lat);
      checks++;
      if (lat !== 2 || e !== 1'b0 || o !== x_tab[i]) begin
        errors++;
        $display("FAIL load_ext[%0d]: lat=%0d err=%b dout=%h, required lat=2 err=0 dout=%h", i, lat, e, o, x_tab[i]);
      end
      $display("load size=%b uns=%b @%h dout=%h", s_tab[i], u_tab[i], a_tab[i], o);
    end
  endtask

  task automatic test_errors();
    logic        w_tab [10] = '{0, 0, 1, 1, 1, 0, 1, 1, 1, 0};
    logic [1:0]  s_tab [10] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b01, 2'b11, 2'b00};
    logic [31:0] a_tab [10] = '{32'h20, 32'h21, 32'h20, 32'h3FE, 32'h400, 32'h3FC, 32'h3FE, 32'h3FF,
                                32'hFFFFFFFC, 32'h400};
    logic [31:0] d_tab [10] = '{32'h11223344, 32'h0000BBAA, 0, 0, 0, 32'hCAFEF00D, 0, 0, 0, 32'h77};
    logic [31:0] x_tab [10] = '{0, 0, 32'h11223344, 0, 0, 0, 32'hFFFFCAFE, 0, 0, 0};
    logic        e_tab [10] = '{0, 1, 0, 1, 1, 0, 0, 1, 1, 1};
    logic [31:0] o; logic e; int lat;
    for (int i = 0; i < 10; i++) begin
      access(w_tab[i], s_tab[i], 1'b0, a_tab[i], d_tab[i], o, e, lat);
      checks++;
      if (lat !== 2 || e !== e_tab[i] || o !== x_tab[i]) begin
        errors++;
        $display("FAIL err_case[%0d]: lat=%0d err=%b dout=%h, required lat=2 err=%b dout=%h",
                 i, lat, e, o, e_tab[i], x_tab[i]);
      end
      $display("access wen=%b size=%b @%h err=%b dout=%h", w_tab[i], s_tab[i], a_tab[i], e, o);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] o; logic e; int lat;
    @(posedge clk);
    req = 1'b1; wen = 1'b0; size = 2'b10; addr = 32'h10; din = 32'h12345678;
    @(negedge clk);
    @(posedge clk);
    req = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_reset: busy=%b, required 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, dout} !== 35'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b err=%b dout=%h, required all 0", busy, done, err, dout);
    end
    @(negedge clk);
    @(posedge clk);
    rst_n = 1'b1;
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, o, e, lat);
    checks++;
    if (lat !== 2 || e !== 1'b0 || o !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_discarded: lat=%0d err=%b dout=%h, required lat=2 err=0 dout=deadbeef", lat, e, o);
    end
    $display("load after mid-wait reset dout=%h", o);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_tab [2] = '{32'd12, 32'd24};
    logic [31:0] x_tab [2] = '{32'h103, 32'h106};
    logic exp_b, exp_d;
    bit seen;
    @(posedge clk);
    req3 = 1'b1; wen3 = 1'b0; size3 = 2'b10; addr3 = 32'd0; din3 = 32'h100;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      @(posedge clk);
      exp_b = (k % 3) != 2;
      exp_d = (k % 3) == 2;
      checks++;
      if (busy3 !== exp_b || done3 !== exp_d) begin
        errors++;
        $display("FAIL b2b_edge%0d: busy=%b done=%b, required busy=%b done=%b", k, busy3, done3, exp_b, exp_d);
      end
      $display("b2b edge %0d busy=%b done=%b", k, busy3, done3);
      addr3 = 32'(4 * (k + 1));
      din3  = 32'h100 + 32'(k + 1);
    end
    req3 = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      @(posedge clk);
      req3 = 1'b1; wen3 = 1'b1; size3 = 2'b10; addr3 = a_tab[j];
      @(negedge clk);
      seen = 1'b0;
      for (int i = 1; i <= 6 && !seen; i++) begin
        @(posedge clk);
        req3 = 1'b0;
        if (done3) seen = 1'b1;
      end
      checks++;
      if (!seen || dout3 !== x_tab[j] || err3 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_load%0d: done=%b err=%b dout=%h, required done=1 err=0 dout=%h", j, seen, err3, dout3, x_tab[j]);
      end
      $display("lat3 load @%0d dout=%h", a_tab[j], dout3);
      @(negedge clk);
    end
  endtask

  task automatic test_latency1();
    logic [31:0] x_tab [2] = '{32'h000000A5, 32'hFFFFFFA5};
    @(posedge clk);
    req1 = 1'b1; wen1 = 1'b0; size1 = 2'b00; addr1 = 32'd5; din1 = 32'h123456A5;
    @(negedge clk);
    @(posedge clk);
    checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || err1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1_store: done=%b busy=%b err=%b, required done=1 busy=0 err=0", done1, busy1, err1);
    end
    $display("lat1 store byte @5 done=%b", done1);
    wen1 = 1'b1; uns1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      @(posedge clk);
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || dout1 !== x_tab[i]) begin
        errors++;
        $display("FAIL lat1_load%0d: done=%b busy=%b dout=%h, required done=1 busy=0 dout=%h", i, done1, busy1, dout1, x_tab[i]);
      end
      $display("lat1 load byte uns=%b dout=%h", uns1, dout1);
      uns1 = 1'b0;
    end
    req1 = 1'b0;
    @(negedge clk);
    @(posedge clk);
    checks++;
    if (done1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1_idle: done=%b busy=%b, required done=0 busy=0", done1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_load_ext();
    test_errors();
    test_reset_mid_wait();
    test_back_to_back();
    test_latency1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
